// File: rtl/simon_button_reader_if.sv
// ============================================================================
//  Module      : simon_button_reader_if
//  Description : Bundle of signals between the Simon button reader and the
//                game controller: raw buttons and mode flags in, the one-entry
//                press buffer (valid/ready/code) plus LED echo and overflow out.
//  Ports       : btn[3:0], simonTurn, gameOver, press_ready  -> reader
//                press_valid, press_code[1:0], btn_level[3:0],
//                overflow                                    <- reader
//  Modports    : master = button reader, slave = game controller side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_button_reader_if;
    logic [3:0] btn;
    logic       simonTurn;
    logic       gameOver;
    logic       press_ready;
    logic       press_valid;
    logic [1:0] press_code;
    logic [3:0] btn_level;
    logic       overflow;

    modport master (
        input  btn, simonTurn, gameOver, press_ready,
        output press_valid, press_code, btn_level, overflow
    );

    modport slave (
        output btn, simonTurn, gameOver, press_ready,
        input  press_valid, press_code, btn_level, overflow
    );
endinterface

`default_nettype wire

// File: rtl/simon_button_reader.sv
// ============================================================================
//  Module      : simon_button_reader
//  Description : Player-input front end for Simon. Two-flop synchronises the
//                four colour buttons, debounces the whole vector with one
//                shared counter, turns a clean single press from all-released
//                into a colour code and holds it in a one-entry valid/ready
//                buffer for the game controller.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - simon_button_reader_if.master (btn, simonTurn,
//                       gameOver, press_ready in; press_valid, press_code,
//                       btn_level, overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_button_reader #(
    parameter int DEBOUNCE_CYCLES = 50_000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    simon_button_reader_if.master bus
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter value on the edge whose increment would reach the target.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [1:0]       r_code;
    logic             r_overflow;

    logic             w_settle;
    logic             w_press;
    logic [1:0]       w_code;

    // The vector has differed from the stable value long enough to be taken.
    assign w_settle = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

    // Only a transition from all-released to exactly one button counts, and
    // only while it is the player's turn.
    assign w_press  = w_settle && (r_stable == 4'd0) && $onehot(r_sync2)
                      && !bus.simonTurn && !bus.gameOver;

    always_comb begin
        w_code = 2'd0;
        case (r_sync2)
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    // Synchroniser and shared debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 4'd0;
            r_sync2  <= 4'd0;
            r_stable <= 4'd0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= bus.btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // One-entry press buffer. A flush from gameOver wins over everything; a
    // press may load into a slot that is being drained on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_code     <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (bus.gameOver) begin
                r_valid <= 1'b0;
            end else if (w_press) begin
                if (r_valid && !bus.press_ready) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_valid <= 1'b1;
                    r_code  <= w_code;
                end
            end else if (bus.press_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.press_valid = r_valid;
    assign bus.press_code  = r_code;
    assign bus.btn_level   = r_stable;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_simon_button_reader.sv
// ============================================================================
//  Module      : tb_simon_button_reader
//  Description : Self-checking bench for simon_button_reader. A behavioural
//                model (sliding window of synchronised samples and a queue
//                standing in for the one-entry buffer) predicts every output
//                each cycle; directed scenarios add fixed-value checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_button_reader;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simon_button_reader_if bus ();

    simon_button_reader #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0] m_s1, m_s2, m_stable;
    logic [3:0] m_win[$];   // synchronised samples seen since the last accept
    int         m_buf[$];   // pending press codes, at most one entry
    bit         m_ovf;

    always @(posedge clk or posedge rst) begin
        logic [3:0] seen;
        bit         all_diff;
        bit         press;
        int         code;
        if (rst) begin
            m_s1 = 4'd0;
            m_s2 = 4'd0;
            m_stable = 4'd0;
            m_win.delete();
            m_buf.delete();
            m_ovf = 1'b0;
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = bus.btn;
            m_win.push_back(seen);
            if (m_win.size() > DEB) void'(m_win.pop_front());
            // Accept when the last DEB samples all differ from the level held.
            all_diff = (m_win.size() == DEB);
            foreach (m_win[i]) if (m_win[i] == m_stable) all_diff = 1'b0;
            press = 1'b0;
            code  = 0;
            if (all_diff) begin
                press = (m_stable == 4'd0) && ($countones(seen) == 1)
                        && !bus.simonTurn && !bus.gameOver;
                for (int b = 0; b < 4; b++) if (seen[b]) code = b;
                m_stable = seen;
                m_win.delete();
            end
            m_ovf = 1'b0;
            if (bus.gameOver) begin
                m_buf.delete();
            end else begin
                if (bus.press_ready && m_buf.size() > 0) void'(m_buf.pop_front());
                if (press) begin
                    if (m_buf.size() == 0) m_buf.push_back(code);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("btn_level", bus.btn_level, m_stable);
            check("press_valid", bus.press_valid, m_buf.size() > 0);
            if (m_buf.size() > 0) check("press_code", bus.press_code, m_buf[0]);
            check("overflow", bus.overflow, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        bus.press_ready = 1'b1;
        tick(1);
        bus.press_ready = 1'b0;
    endtask

    initial begin
        bus.btn         = 4'd0;
        bus.simonTurn   = 1'b0;
        bus.gameOver    = 1'b0;
        bus.press_ready = 1'b0;
        rst             = 1'b1;
        tick(2);
        check("rst_level", bus.btn_level, 0);
        check("rst_valid", bus.press_valid, 0);
        check("rst_code", bus.press_code, 0);
        check("rst_ovf", bus.overflow, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Clean press: stable and press appear on the fifth edge after sync.
        bus.btn = 4'b0100;
        tick(5);
        check("t1_early_valid", bus.press_valid, 0);
        tick(1);
        check("t1_valid", bus.press_valid, 1);
        check("t1_code", bus.press_code, 2);
        check("t1_level", bus.btn_level, 4'b0100);
        drain();
        check("t1_drained", bus.press_valid, 0);
        bus.btn = 4'd0;
        tick(8);

        // Bounce never lasts long enough; the final hold produces one press.
        repeat (5) begin
            bus.btn = 4'b0001; tick(2);
            bus.btn = 4'b0000; tick(2);
        end
        check("t2_no_bounce_evt", bus.press_valid, 0);
        bus.btn = 4'b0001;
        tick(5);
        check("t2_early_valid", bus.press_valid, 0);
        tick(1);
        check("t2_valid", bus.press_valid, 1);
        check("t2_code", bus.press_code, 0);
        drain();
        bus.btn = 4'd0;
        tick(8);

        // Multi-press and transitions from non-zero are ignored.
        bus.btn = 4'b0011; tick(8);
        check("t3_level_2hot", bus.btn_level, 4'b0011);
        check("t3_no_2hot", bus.press_valid, 0);
        bus.btn = 4'b0001; tick(8);
        check("t3_no_from_nz", bus.press_valid, 0);
        bus.btn = 4'b0000; tick(8);
        bus.btn = 4'b1000; tick(6);
        check("t3_valid", bus.press_valid, 1);
        check("t3_code", bus.press_code, 3);
        drain();
        bus.btn = 4'd0;
        tick(8);

        // Overflow: second press while the first is still held.
        bus.btn = 4'b0010; tick(8);
        bus.btn = 4'b0000; tick(8);
        bus.btn = 4'b1000; tick(5);
        check("t4_ovf_early", bus.overflow, 0);
        tick(1);
        check("t4_ovf", bus.overflow, 1);
        check("t4_valid", bus.press_valid, 1);
        check("t4_code", bus.press_code, 1);
        tick(1);
        check("t4_ovf_pulse", bus.overflow, 0);
        drain();
        bus.btn = 4'd0;
        tick(8);

        // Gating: simonTurn suppresses, gameOver flushes.
        bus.simonTurn = 1'b1;
        bus.btn = 4'b0010; tick(8);
        check("t5_level", bus.btn_level, 4'b0010);
        check("t5_suppressed", bus.press_valid, 0);
        bus.btn = 4'b0000; tick(8);
        bus.simonTurn = 1'b0;
        bus.btn = 4'b0010; tick(8);
        check("t5_pending", bus.press_valid, 1);
        bus.gameOver = 1'b1; tick(1);
        check("t5_flush", bus.press_valid, 0);
        bus.gameOver = 1'b0;
        bus.btn = 4'd0;
        tick(8);

        // Load on the same edge as a drain.
        bus.btn = 4'b0001; tick(8);
        bus.btn = 4'b0000; tick(8);
        bus.btn = 4'b1000; tick(5);
        bus.press_ready = 1'b1; tick(1);
        bus.press_ready = 1'b0;
        check("t6_valid", bus.press_valid, 1);
        check("t6_code", bus.press_code, 3);
        check("t6_ovf", bus.overflow, 0);
        drain();
        bus.btn = 4'd0;
        tick(8);

        // Asynchronous reset mid-debounce with a press pending.
        bus.btn = 4'b0100; tick(8);
        bus.btn = 4'b0000; tick(2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_level", bus.btn_level, 0);
        check("t6_rst_valid", bus.press_valid, 0);
        check("t6_rst_code", bus.press_code, 0);
        check("t6_rst_ovf", bus.overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(8);
        check("t6_no_evt_after", bus.press_valid, 0);

        // Randomised segments against the model.
        repeat (200) begin
            int kind;
            int hold;
            kind = $urandom_range(0, 9);
            if (kind < 2)      bus.btn = 4'd0;
            else if (kind < 8) bus.btn = 4'(1 << $urandom_range(0, 3));
            else               bus.btn = 4'($urandom_range(0, 15));
            bus.simonTurn = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 10);
            repeat (hold) begin
                bus.press_ready = ($urandom_range(0, 3) == 0);
                bus.gameOver    = ($urandom_range(0, 31) == 0);
                tick(1);
            end
        end
        bus.press_ready = 1'b0;
        bus.gameOver    = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simon_button_reader.md
Name: simon_button_reader

Overview:
- Player-input front end for the Simon game; it is the input-side counterpart of the 7-segment status display.
- Synchronises and debounces the four raw colour push-buttons.
- Converts each clean single-button press into an encoded colour event.
- Holds the event in a one-entry buffer with a valid/ready handshake to the game controller.
- Accepts presses only during the player's turn (simonTurn=0, gameOver=0).

Parameters:
- DEBOUNCE_CYCLES, 50_000: consecutive clk edges a new button vector must persist before it is accepted (1 ms at 50 MHz). Legal range 2..2^20-1. Benches use 4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- btn  input  4  raw asynchronous buttons, active-high; bit0=green, bit1=red, bit2=yellow, bit3=blue
- simonTurn  input  1  1 = Simon playing sequence, presses ignored
- gameOver  input  1  1 = game ended, presses ignored, pending press flushed
- press_ready  input  1  controller accepts the pending press this cycle
- press_valid  output  1  a press event is pending
- press_code  output  2  encoded colour of the pending press (index of the pressed bit)
- btn_level  output  4  debounced button levels, for LED echo
- overflow  output  1  one-cycle pulse: a press was dropped because the buffer was full

Behaviour:
- Reset (async, rst=1): sync stages=0, stable=0, debounce counter=0, press_valid=0, press_code=0, btn_level=0, overflow=0. Release is taken on the next clk edge.
- Synchroniser: two flip-flop stages per bit (sync1 -> sync2). No logic between the stages.
- Debounce: a single counter, width $clog2(DEBOUNCE_CYCLES+1), is shared by the whole 4-bit vector. On each edge:
  - if sync2 == stable, the counter is cleared;
  - otherwise it increments;
  - on the edge where the increment would reach DEBOUNCE_CYCLES, stable <= sync2 and the counter is cleared.
  - Any bounce back to the stable value restarts the count.
- btn_level = stable (registered).
- Press detect: evaluated on the edge where stable updates.
  - A press is generated only if old stable == 0, new stable is one-hot, simonTurn=0 and gameOver=0.
  - press_code = index of the set bit.
  - Two-hot or wider vectors, and transitions from non-zero, never generate a press. The player must release all buttons before the next press counts.
  - Releases never generate events.
- Latency: raw btn changes before edge 0 -> sync2 updates at edge 1 -> mismatch seen at edges 2..DEBOUNCE_CYCLES+1 -> stable and press_valid update at edge DEBOUNCE_CYCLES+1.
- Handshake / buffer (one entry):
  - The event transfers on an edge with press_valid & press_ready; press_valid then falls unless a new press loads on the same edge.
  - New press with buffer empty, or draining on the same edge: load it; press_valid=1, press_code=new value.
  - New press with press_valid=1 and press_ready=0: the new press is dropped, the held press_code is unchanged, overflow=1 for exactly that one cycle.
  - press_valid and press_code stay stable while waiting for press_ready.
- Mode gating:
  - gameOver=1 at an edge clears press_valid (flush) and suppresses new presses; flush has priority over load.
  - simonTurn=1 suppresses new presses but does not flush a pending one.
  - Debouncing and btn_level run regardless of mode.
- rst asserted mid-debounce or with a pending press: everything clears immediately. No event is emitted after release unless a fresh press completes debounce.

Test Plan (DEBOUNCE_CYCLES=4):
1. Clean press: after reset, btn=0100 held with press_ready=0 -> btn_level=0100 and press_valid=1, press_code=2 after edge 5. Then press_ready=1 for one cycle -> press_valid=0 next edge.
2. Bounce: btn toggles 0001/0000 every 2 cycles for 20 cycles, then holds 0001 -> no event during toggling; exactly one press, code 0, 5 edges after the final hold begins.
3. Multi-press: btn=0011 applied at once -> btn_level=0011, no press. Then btn=0001 (from non-zero) -> no press. Then btn=0000, then 1000 -> press, code 3.
4. Overflow: press red (code 1) with press_ready=0, release, press blue -> overflow pulses 1 cycle, press_valid stays 1, press_code stays 1.
5. Gating: simonTurn=1 during press -> no event, btn_level still 0010. Pending press then gameOver=1 -> press_valid=0 next edge.
6. Simultaneous: press_valid=1, press_ready=1 on the same edge a new press (code 3) completes -> press_valid stays 1, press_code=3, overflow=0. Mid-debounce rst pulse -> all outputs 0 immediately.
